// File: rtl/pio_in_pkg.sv
// Shared constants for the ball-detect input PIO: register word addresses,
// edge-capture modes and the debounce counter sizing helper.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_TS      = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Wide enough to hold DEBOUNCE_CYCLES; at least one bit so the bypass build still elaborates.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One sensor line: 2-flop synchroniser followed by a level debounce filter.
// DEBOUNCE_CYCLES=0 passes the synchronised level straight through.
module pio_in_debounce
  import pio_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  // NOTE: non-blocking assignments in always_ff so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb = sync_q;
    end else begin : g_filter
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic          deb_q, deb_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Any cycle where the input agrees with the accepted level restarts the window.
      always_comb begin
        // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch).
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
          if (cnt_q == LAST) deb_d = sync_q;
          else               cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          deb_q <= deb_d;
          cnt_q <= cnt_d;
        end
      end

      assign deb = deb_q;
    end
  endgenerate

endmodule

// File: rtl/pio_ball_detect_in.sv
// Avalon-MM input PIO for the IR ball-detect sensors: debounce, edge capture, level IRQ.
// Optional PIO_BALL_DETECT_TIMESTAMP_EN adds a 16-bit cycle timestamp of the first captured edge at address 2.
module pio_ball_detect_in
  import pio_in_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned EDGE_MODE       = 0,
`ifdef PIO_BALL_DETECT_TIMESTAMP_EN
  localparam int unsigned RD_W = (DATA_WIDTH > 16) ? DATA_WIDTH : 16
`else
  localparam int unsigned RD_W = DATA_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [1:0]            address,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [RD_W-1:0]       readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] deb;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pio_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .deb     (deb[i])
    );
  end

  logic [DATA_WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [DATA_WIDTH-1:0] edge_q, edge_d;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [RD_W-1:0]       readdata_q, readdata_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] edge_evt, clr;
  logic [RD_W-1:0]       rd_mux;
  logic                  wr_en, rd_en;

`ifdef PIO_BALL_DETECT_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic [15:0] ts_q, ts_d;
`endif

  always_comb begin
    wr_en     = chipselect && !write_n;
    rd_en     = chipselect && !read_n;
    deb_dly_d = deb;

    if (EDGE_MODE == EDGE_FALL)     edge_evt = ~deb & deb_dly_q;
    else if (EDGE_MODE == EDGE_ANY) edge_evt = deb ^ deb_dly_q;
    else                            edge_evt = deb & ~deb_dly_q;

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_IRQMASK) irq_mask_d = writedata;

    // A new edge is OR-ed in after the clear, so it survives a same-cycle W1C.
    clr    = (wr_en && address == ADDR_EDGE) ? writedata : '0;
    edge_d = (edge_q & ~clr) | edge_evt;

    irq_d = |(edge_q & irq_mask_q);

    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = RD_W'(deb);
      ADDR_IRQMASK: rd_mux = RD_W'(irq_mask_q);
      ADDR_EDGE:    rd_mux = RD_W'(edge_q);
`ifdef PIO_BALL_DETECT_TIMESTAMP_EN
      ADDR_TS:      rd_mux = RD_W'(ts_q);
`endif
      default:      rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
  end

`ifdef PIO_BALL_DETECT_TIMESTAMP_EN
  // Latch only on the empty-to-nonempty transition; a full clear also wipes the stamp.
  always_comb begin
    ts_cnt_d = ts_cnt_q + 16'd1;
    ts_d     = ts_q;
    if (edge_d == '0)      ts_d = '0;
    else if (edge_q == '0) ts_d = ts_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q  <= '0;
      edge_q     <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_dly_q  <= deb_dly_d;
      edge_q     <= edge_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
